// File: rtl/mac_stream_accum.sv
// Streaming multiply-accumulate: TAPS operand pairs per window summed onto a bias, one result per window.
// Optional MAC_SAT_EN: saturating accumulation with a sticky per-window sat flag (wraps modulo 2^Ly otherwise).
module mac_stream_accum #(
    parameter int La   = 8,
    parameter int Lb   = 8,
    parameter int Lc   = 16,
    parameter int Ly   = 24,
    parameter int TAPS = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [La-1:0] A,
    input  logic [Lb-1:0] B,
    input  logic [Lc-1:0] C,
    input  logic          sg,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [Ly-1:0] Y,
    output logic          sat
);
    localparam int Lp = La + Lb;
    localparam int CW = $clog2(TAPS + 1);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] tap_cnt_reg, tap_cnt_next;
    logic          drain_reg, drain_next;

    logic          mode_sg_reg;
    logic [Ly-1:0] bias_reg;
    logic [Lp-1:0] p_reg;
    logic          p_valid_reg;
    logic          p_first_reg;
    logic [Ly-1:0] acc_reg;

    logic          xfer;
    logic          first_tap;
    logic          eff_sg;
    logic [Ly-1:0] c_ext;
    logic [Ly-1:0] p_ext;
    logic [Ly-1:0] base;
    logic [Ly-1:0] acc_sum;

    assign in_ready  = (state_reg == IDLE) || (state_reg == ACC);
    assign out_valid = (state_reg == DONE);
    assign xfer      = in_valid && in_ready;
    assign first_tap = xfer && (state_reg == IDLE);
    assign Y         = acc_reg;

    // The first tap's product is formed before mode_sg_reg is loaded, so take sg directly then.
    assign eff_sg = (state_reg == IDLE) ? sg : mode_sg_reg;

    // One extra operand bit (sign or zero) lets a single signed multiplier serve both modes.
    logic signed [La:0]   a_ext;
    logic signed [Lb:0]   b_ext;
    logic signed [Lp+1:0] prod_full;
    assign a_ext     = {eff_sg & A[La-1], A};
    assign b_ext     = {eff_sg & B[Lb-1], B};
    assign prod_full = a_ext * b_ext;

    for (genvar gi = 0; gi < Ly; gi++) begin : g_ext
        if (gi < Lc) begin : g_c_low
            assign c_ext[gi] = C[gi];
        end else begin : g_c_high
            assign c_ext[gi] = eff_sg & C[Lc-1];
        end
        if (gi < Lp) begin : g_p_low
            assign p_ext[gi] = p_reg[gi];
        end else begin : g_p_high
            assign p_ext[gi] = mode_sg_reg & p_reg[Lp-1];
        end
    end

    assign base = p_first_reg ? bias_reg : acc_reg;

`ifdef MAC_SAT_EN
    logic [Ly:0] sum_full;
    logic        ovf_pos, ovf_neg, ovf_u;
    logic        clamp;
    logic        sat_reg;

    assign sum_full = {1'b0, base} + {1'b0, p_ext};
    assign ovf_pos  = !base[Ly-1] && !p_ext[Ly-1] && sum_full[Ly-1];
    assign ovf_neg  = base[Ly-1] && p_ext[Ly-1] && !sum_full[Ly-1];
    assign ovf_u    = sum_full[Ly];

    always_comb begin
        acc_sum = sum_full[Ly-1:0];
        clamp   = 1'b0;
        if (mode_sg_reg) begin
            if (ovf_pos) begin
                acc_sum = {1'b0, {(Ly-1){1'b1}}};
                clamp   = 1'b1;
            end else if (ovf_neg) begin
                acc_sum = {1'b1, {(Ly-1){1'b0}}};
                clamp   = 1'b1;
            end
        end else if (ovf_u) begin
            acc_sum = {Ly{1'b1}};
            clamp   = 1'b1;
        end
    end

    // Sticky across the window; cleared when the next window's first tap arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_reg <= 1'b0;
        end else if (first_tap) begin
            sat_reg <= 1'b0;
        end else if (p_valid_reg && clamp) begin
            sat_reg <= 1'b1;
        end
    end

    assign sat = sat_reg;
`else
    assign acc_sum = base + p_ext;
    assign sat     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            tap_cnt_reg <= '0;
            drain_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tap_cnt_reg <= tap_cnt_next;
            drain_reg   <= drain_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tap_cnt_next = tap_cnt_reg;
        drain_next   = drain_reg;
        unique case (state_reg)
            IDLE: begin
                if (xfer) begin
                    tap_cnt_next = CW'(1);
                    state_next   = ACC;
                end
            end
            ACC: begin
                if (xfer) begin
                    tap_cnt_next = tap_cnt_reg + CW'(1);
                    if (tap_cnt_reg == CW'(TAPS - 1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Two cycles: last product lands in P1, then in the accumulator.
                drain_next = !drain_reg;
                if (drain_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    tap_cnt_next = '0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sg_reg <= 1'b0;
            bias_reg    <= '0;
            p_reg       <= '0;
            p_valid_reg <= 1'b0;
            p_first_reg <= 1'b0;
            acc_reg     <= '0;
        end else begin
            if (first_tap) begin
                mode_sg_reg <= sg;
                bias_reg    <= c_ext;
            end
            if (xfer) begin
                p_reg <= prod_full[Lp-1:0];
            end
            p_valid_reg <= xfer;
            p_first_reg <= first_tap;
            if (p_valid_reg) begin
                acc_reg <= acc_sum;
            end
        end
    end
endmodule

// File: tb/tb_mac_stream_accum.sv
// Directed bench for mac_stream_accum: a 4-tap 24-bit instance and a 2-tap 16-bit instance for clamp/wrap.
module tb_mac_stream_accum;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] c = '0;
    logic        sg = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy0, ov0, sat0;
    logic [23:0] y0;
    logic        rdy1, ov1, sat1;
    logic [15:0] y1;

    logic        tgt = 1'b0;
    logic        rdy_s, ov_s, sat_s;
    logic [31:0] y_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_stream_accum #(.La(8), .Lb(8), .Lc(16), .Ly(24), .TAPS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .A(a), .B(b), .C(c), .sg(sg), .out_valid(ov0), .out_ready(out_ready),
        .Y(y0), .sat(sat0)
    );

    mac_stream_accum #(.La(8), .Lb(8), .Lc(16), .Ly(16), .TAPS(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .A(a), .B(b), .C(c), .sg(sg), .out_valid(ov1), .out_ready(out_ready),
        .Y(y1), .sat(sat1)
    );

    always_comb begin
        rdy_s = tgt ? rdy1 : rdy0;
        ov_s  = tgt ? ov1 : ov0;
        sat_s = tgt ? sat1 : sat0;
        y_s   = tgt ? {16'h0, y1} : {8'h0, y0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Holds in_valid high with the given pair until the target accepts it; returns edges waited.
    task automatic send_tap(input logic [7:0] a_v, input logic [7:0] b_v, input logic [15:0] c_v,
                            input logic sg_v, output int waited);
        logic took;
        in_valid = 1'b1;
        a = a_v; b = b_v; c = c_v; sg = sg_v;
        waited = 0;
        do begin
            took = rdy_s;
            @(posedge clk); #1;
            waited++;
        end while (!took && waited < 50);
        if (!took) check("tap_timeout", 32'(took), 32'd1);
    endtask

    task automatic bubble(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called #1 after the last tap's edge: checks drain, latency, result, optional stall, then accepts.
    task automatic finish_window(input string tag, input logic [31:0] exp_y, input logic exp_sat,
                                 input int stall);
        int lat;
        in_valid = 1'b0;
        check({tag, "_drain_rdy"}, 32'(rdy_s), 32'd0);
        lat = 0;
        while (!ov_s && lat < 20) begin @(posedge clk); #1; lat++; end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_y"}, y_s, exp_y);
        check({tag, "_sat"}, 32'(sat_s), 32'(exp_sat));
        $display("window %s: Y=%0h sat=%0b latency=%0d", tag, y_s, sat_s, lat);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_ov"}, 32'(ov_s), 32'd1);
            check({tag, "_hold_y"}, y_s, exp_y);
            check({tag, "_hold_rdy"}, 32'(rdy_s), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_accept_ov"}, 32'(ov_s), 32'd0);
        check({tag, "_accept_rdy"}, 32'(rdy_s), 32'd1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        tgt = 1'b0;
        do_reset();
        check("reset_rdy", 32'(rdy0), 32'd1);
        check("reset_ov", 32'(ov0), 32'd0);
        check("reset_y", {8'h0, y0}, 32'd0);
        check("reset_sat", 32'(sat0), 32'd0);

        // Unsigned, C=10, 255*255 x4: 10 + 4*65025 = 260110; out_ready withheld 5 cycles.
        for (int i = 0; i < 4; i++) send_tap(8'd255, 8'd255, 16'd10, 1'b0, w);
        finish_window("unsigned_max", 32'd260110, 1'b0, 5);

        // Signed, C=-10: -16256 + 1 - 30 + 6 = -16289 -> 24'hFFC05F; sg/C on later taps ignored.
        send_tap(8'h80, 8'h7F, 16'hFFF6, 1'b1, w);
        check("b2b_first_tap_wait", 32'(w), 32'd1);
        send_tap(8'hFF, 8'hFF, 16'h1234, 1'b0, w);
        send_tap(8'd5, 8'hFA, 16'h7777, 1'b0, w);
        send_tap(8'd2, 8'd3, 16'h0001, 1'b1, w);
        finish_window("signed_mix", 32'h00FFC05F, 1'b0, 0);

        // Bubbles between taps: 1000 + 12 + 20000 + 0 + 4335 = 25347.
        send_tap(8'd3, 8'd4, 16'd1000, 1'b0, w);
        bubble(2);
        send_tap(8'd200, 8'd100, 16'd0, 1'b1, w);
        bubble(1);
        send_tap(8'd0, 8'd9, 16'd0, 1'b0, w);
        bubble(3);
        send_tap(8'd17, 8'd255, 16'd0, 1'b0, w);
        finish_window("bubbles", 32'd25347, 1'b0, 0);

        // Reset after 2 of 4 taps: outputs return at once, no residue afterwards.
        send_tap(8'd100, 8'd100, 16'd500, 1'b0, w);
        send_tap(8'd100, 8'd100, 16'd500, 1'b0, w);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_rdy", 32'(rdy0), 32'd1);
        check("midreset_ov", 32'(ov0), 32'd0);
        check("midreset_y", {8'h0, y0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Signed C=5 with four (-1)*1 products: 5 - 4 = 1.
        for (int i = 0; i < 4; i++) send_tap(8'hFF, 8'd1, 16'd5, 1'b1, w);
        finish_window("post_reset", 32'd1, 1'b0, 0);

        // 16-bit instance, 2 taps of 127*127 = 16129 each.
        tgt = 1'b1;
        do_reset();
        check("reset16_y", {16'h0, y1}, 32'd0);
        check("reset16_sat", 32'(sat1), 32'd0);
        for (int i = 0; i < 2; i++) send_tap(8'd127, 8'd127, 16'd0, 1'b1, w);
        finish_window("l16_nosat", 32'd32258, 1'b0, 0);
        for (int i = 0; i < 2; i++) send_tap(8'd127, 8'd127, 16'h7FFF, 1'b1, w);
`ifdef MAC_SAT_EN
        finish_window("l16_pos_clamp", 32'h7FFF, 1'b1, 2);
`else
        finish_window("l16_pos_wrap", 32'hFE01, 1'b0, 2);
`endif
        // sat must clear on the next window's first tap.
        for (int i = 0; i < 2; i++) send_tap(8'd127, 8'd127, 16'd0, 1'b1, w);
        finish_window("l16_sat_clear", 32'd32258, 1'b0, 0);
        // Unsigned: 65535 + 2*65025 overflows; wrap gives 195585 mod 65536 = 0xFC01.
        for (int i = 0; i < 2; i++) send_tap(8'd255, 8'd255, 16'hFFFF, 1'b0, w);
`ifdef MAC_SAT_EN
        finish_window("l16_u_clamp", 32'hFFFF, 1'b1, 0);
`else
        finish_window("l16_u_wrap", 32'hFC01, 1'b0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
